mem_port_arbiter: RTL

- Shares one single-port unified memory between the core's instruction-fetch requester and its load/store requester.
- Sits between the core's iAddr/iMemData and dAddr/WriteData/MemWrite/dMemData paths and the external memory port.
- Default priority goes to data accesses. A starvation limiter guarantees instruction fetch forward progress.
- A watchdog aborts memory transactions that never complete.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store requesters.
// Data wins by default; a starvation limiter forces fetch through and a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    localparam logic [3:0] L_STARVE_MAX   = 4'(STARVE_MAX);
    localparam logic [7:0] L_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_starve_cnt;
    logic [7:0]  r_timeout_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_valid;
    logic        r_d_valid;
    logic        r_err;

    state_t      w_state_nxt;
    logic [3:0]  w_starve_cnt_nxt;
    logic [7:0]  w_timeout_cnt_nxt;
    logic        w_mem_req_nxt;
    logic        w_mem_we_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [31:0] w_i_rdata_nxt;
    logic [31:0] w_d_rdata_nxt;
    logic        w_i_valid_nxt;
    logic        w_d_valid_nxt;
    logic        w_err_nxt;

    // Next-state and next-output computation; completion pulses default low so they last one cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_starve_cnt_nxt  = r_starve_cnt;
        w_timeout_cnt_nxt = r_timeout_cnt;
        w_mem_req_nxt     = r_mem_req;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_i_rdata_nxt     = r_i_rdata;
        w_d_rdata_nxt     = r_d_rdata;
        w_i_valid_nxt     = 1'b0;
        w_d_valid_nxt     = 1'b0;
        w_err_nxt         = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_req && (!d_req || (r_starve_cnt == L_STARVE_MAX))) begin
                    w_state_nxt      = BUSY_I;
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = i_addr;
                    w_starve_cnt_nxt = 4'd0;
                end else if (d_req) begin
                    w_state_nxt     = BUSY_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    // Count only data grants that actually passed over a waiting fetch.
                    if (i_req) begin
                        if (r_starve_cnt < L_STARVE_MAX) begin
                            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
                        end else begin
                            w_starve_cnt_nxt = r_starve_cnt;
                        end
                    end else begin
                        w_starve_cnt_nxt = 4'd0;
                    end
                end else begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    if (r_state == BUSY_I) begin
                        w_i_rdata_nxt = mem_rdata;
                    end else if (!r_mem_we) begin
                        w_d_rdata_nxt = mem_rdata;
                    end else begin
                        w_d_rdata_nxt = r_d_rdata;
                    end
                    w_mem_req_nxt     = 1'b0;
                    w_mem_we_nxt      = 1'b0;
                    w_timeout_cnt_nxt = 8'd0;
                    w_i_valid_nxt     = (r_state == BUSY_I);
                    w_d_valid_nxt     = (r_state == BUSY_D);
                    w_state_nxt       = (r_state == BUSY_I) ? DONE_I : DONE_D;
                end else if (r_timeout_cnt == L_TIMEOUT_LAST) begin
                    w_mem_req_nxt     = 1'b0;
                    w_mem_we_nxt      = 1'b0;
                    w_timeout_cnt_nxt = 8'd0;
                    w_err_nxt         = 1'b1;
                    w_i_valid_nxt     = (r_state == BUSY_I);
                    w_d_valid_nxt     = (r_state == BUSY_D);
                    w_state_nxt       = (r_state == BUSY_I) ? DONE_I : DONE_D;
                end else begin
                    w_timeout_cnt_nxt = r_timeout_cnt + 8'd1;
                end
            end
            DONE_I, DONE_D: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
                w_mem_we_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access without a completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_starve_cnt  <= 4'd0;
            r_timeout_cnt <= 8'd0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_i_rdata     <= 32'd0;
            r_d_rdata     <= 32'd0;
            r_i_valid     <= 1'b0;
            r_d_valid     <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_starve_cnt  <= w_starve_cnt_nxt;
            r_timeout_cnt <= w_timeout_cnt_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_i_rdata     <= w_i_rdata_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_i_valid     <= w_i_valid_nxt;
            r_d_valid     <= w_d_valid_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign i_rdata   = r_i_rdata;
    assign i_valid   = r_i_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
